// File: rtl/comm_tx_sequencer.sv
// comm_tx_sequencer: drives 4-bit words into the mux/demux channel one bit
// slot at a time and reassembles the returned bits into rx_word.
//
// Ports:
//   clk, rst         : single rising-edge clock, synchronous active-high reset
//   in_msg/in_valid  : upstream word and its valid
//   in_ready         : buffer can accept (from registered occupancy, = !full)
//   msg_out          : word presented to the channel mux data input
//   sel              : current bit slot 0..3 (0 outside a frame)
//   chan_bit         : bit returned by the channel for the current slot
//   busy             : frame in progress (SEND or DONE)
//   rx_word/rx_valid : reassembled word, one-cycle valid at frame end
//   rx_err/err_count : loopback mismatch flag and saturating counter
//
// Optional feature: define COMM_SEQ_LOOPBACK_CHECK_EN to compare each
// received word with the transmitted one. Undefined, rx_err and err_count
// are tied to 0 and no compare logic exists.
module comm_tx_sequencer #(
   parameter int FIFO_DEPTH  = 2,
   parameter int SLOT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] in_msg,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [3:0] msg_out,
   output logic [1:0] sel,
   input  logic       chan_bit,
   output logic       busy,
   output logic [3:0] rx_word,
   output logic       rx_valid,
   output logic       rx_err,
   output logic [7:0] err_count
);

   localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          empty;

   logic [3:0]    tx_reg;
   logic [3:0]    rx_shift;
   logic [3:0]    shift_nxt;
   logic [CW-1:0] cyc_cnt;
   logic [1:0]    slot;
   logic          slot_end;
   logic          frame_end;

   // Occupancy is registered, so a pop this cycle frees space only next cycle.
   assign in_ready = (count != FULL_CNT);
   assign empty    = (count == '0);
   assign push     = in_valid & in_ready;
   assign slot_end = (cyc_cnt == SLOT_LAST);
   assign msg_out  = tx_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      frame_end = 1'b0;
      busy      = (state != IDLE);
      rx_valid  = (state == DONE);
      sel       = 2'd0;
      shift_nxt = rx_shift;
      shift_nxt[slot] = chan_bit;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            sel = slot;
            if (slot_end && (slot == 2'd3)) begin
               frame_end = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            // Chain straight into the next frame when a word is waiting.
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = SEND;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= in_msg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         tx_reg   <= 4'd0;
         rx_shift <= 4'd0;
         rx_word  <= 4'd0;
         slot     <= 2'd0;
         cyc_cnt  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pop) begin
            tx_reg  <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
            slot    <= 2'd0;
            cyc_cnt <= '0;
         end else if (state == SEND) begin
            if (slot_end) begin
               cyc_cnt  <= '0;
               rx_shift <= shift_nxt;
               slot     <= slot + 1'b1;
            end else begin
               cyc_cnt <= cyc_cnt + 1'b1;
            end
         end
         // Last bit arrives on this edge, so take it straight from chan_bit.
         if (frame_end) begin
            rx_word <= shift_nxt;
         end
      end
   end

`ifdef COMM_SEQ_LOOPBACK_CHECK_EN
   logic       err_q;
   logic [7:0] err_cnt;
   logic       mismatch;

   assign mismatch = frame_end && (shift_nxt != tx_reg);

   // Flag is set on the edge into DONE, so it lines up with rx_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q   <= 1'b0;
         err_cnt <= 8'd0;
      end else begin
         err_q <= mismatch;
         if (mismatch && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

   assign rx_err    = err_q;
   assign err_count = err_cnt;
`else
   assign rx_err    = 1'b0;
   assign err_count = 8'd0;
`endif

endmodule
